// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit core: fetches instructions over a
// req/ack handshake, holds them in the IR and turns decoder enables into commit strobes.
module cpu_sequencer #(
    parameter int PROGRAM_DataWidth = 16,
    parameter int MEM_TIMEOUT       = 15,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         step,
    input  logic                         halt_req,
    output logic                         mem_req,
    input  logic                         mem_ack,
    input  logic [PROGRAM_DataWidth-1:0] mem_data,
    output logic [PROGRAM_DataWidth-1:0] ir,
    input  logic                         dec_wr_en,
    input  logic                         dec_stat_wr_en,
    input  logic                         dec_cnt_wr_en,
    output logic                         reg_wr_strobe,
    output logic                         stat_wr_strobe,
    output logic                         pc_load,
    output logic                         pc_inc,
    output logic                         halted,
    output logic                         bus_error,
    output logic [CNT_WIDTH-1:0]         instr_count
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEM_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMEOUT_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [PROGRAM_DataWidth-1:0] r_ir;
    logic                         r_step_mode;
    logic                         w_step_mode_next;
    logic [TW-1:0]                r_timeout;
    logic [TW-1:0]                w_timeout_next;
    logic                         r_bus_error;
    logic [CNT_WIDTH-1:0]         r_instr_count;
    logic                         w_ir_load;
    logic                         w_count_en;
    logic                         w_exec;

    always_comb begin
        w_state_next     = r_state;
        w_step_mode_next = r_step_mode;
        w_timeout_next   = r_timeout;
        w_ir_load        = 1'b0;
        w_count_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // halt_req outranks run, and run outranks step
                if (!halt_req) begin
                    if (run) begin
                        w_state_next     = S_FETCH;
                        w_step_mode_next = 1'b0;
                    end else if (step) begin
                        w_state_next     = S_FETCH;
                        w_step_mode_next = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    w_ir_load      = 1'b1;
                    w_timeout_next = '0;
                    w_state_next   = S_DECODE;
                end else if (r_timeout == TIMEOUT_LAST) begin
                    w_timeout_next = '0;
                    w_state_next   = S_ERROR;
                end else begin
                    w_timeout_next = r_timeout + TIMEOUT_ONE;
                end
            end
            S_DECODE: begin
                w_state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                w_count_en = 1'b1;
                if (r_step_mode || halt_req || !run) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_ERROR: begin
                w_state_next = S_ERROR;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ir          <= '0;
            r_step_mode   <= 1'b0;
            r_timeout     <= '0;
            r_bus_error   <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_step_mode <= w_step_mode_next;
            r_timeout   <= w_timeout_next;
            if (w_ir_load) begin
                r_ir <= mem_data;
            end
            if (w_count_en) begin
                r_instr_count <= r_instr_count + CNT_ONE;
            end
            if (w_state_next == S_ERROR) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    // Strobes are suppressed while reset is asserted so an aborted EXECUTE commits nothing
    assign w_exec         = (r_state == S_EXECUTE) && !reset;
    assign reg_wr_strobe  = w_exec && dec_wr_en;
    assign stat_wr_strobe = w_exec && dec_stat_wr_en;
    assign pc_load        = w_exec && dec_cnt_wr_en;
    assign pc_inc         = w_exec && !dec_cnt_wr_en;

    assign mem_req     = (r_state == S_FETCH);
    assign halted      = (r_state == S_IDLE) || (r_state == S_ERROR);
    assign bus_error   = r_bus_error;
    assign ir          = r_ir;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a program-memory model pushes expected commits
// into a scoreboard when it acks, and each EXECUTE cycle pops and checks them.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, step, halt_req;
    logic        mem_req, mem_ack;
    logic [15:0] mem_data, ir;
    logic        dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en;
    logic        reg_wr_strobe, stat_wr_strobe, pc_load, pc_inc;
    logic        halted, bus_error;
    logic [3:0]  instr_count;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .PROGRAM_DataWidth(16),
        .MEM_TIMEOUT(15),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .step(step),
        .halt_req(halt_req),
        .mem_req(mem_req),
        .mem_ack(mem_ack),
        .mem_data(mem_data),
        .ir(ir),
        .dec_wr_en(dec_wr_en),
        .dec_stat_wr_en(dec_stat_wr_en),
        .dec_cnt_wr_en(dec_cnt_wr_en),
        .reg_wr_strobe(reg_wr_strobe),
        .stat_wr_strobe(stat_wr_strobe),
        .pc_load(pc_load),
        .pc_inc(pc_inc),
        .halted(halted),
        .bus_error(bus_error),
        .instr_count(instr_count)
    );

    // Tiny stand-in for the instruction decoder
    assign dec_wr_en      = (ir == 16'h0800) || (ir == 16'h4800);
    assign dec_stat_wr_en = (ir == 16'h0800);
    assign dec_cnt_wr_en  = ir[15];

    typedef struct {
        logic [15:0] data;
        logic        e_reg;
        logic        e_stat;
        logic        e_load;
    } instr_t;

    instr_t      prog[$];
    instr_t      sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mem_en = 1'b1;
    int          ack_delay = 0;
    int          wait_n = 0;
    logic [15:0] exp_ir = '0;
    logic [3:0]  exp_cnt = '0;
    bit          prev_exec = 1'b0;
    bit          in_decode = 1'b0;
    int          n_exec = 0;
    int          cyc = 0;
    int          last_exec_cyc = 0;
    int          exec_gap = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [15:0] d, input logic r, input logic s, input logic l);
        instr_t e;
        e.data = d; e.e_reg = r; e.e_stat = s; e.e_load = l;
        prog.push_back(e);
    endtask

    // One clock: track IR/counter expectations, run the memory model, check outputs
    task automatic cycle();
        bit          took;
        bit          rst;
        logic [15:0] d;
        instr_t      e;
        took = mem_ack && mem_req;
        rst  = reset;
        d    = mem_data;
        @(posedge clk);
        #1;
        cyc++;
        in_decode = 1'b0;
        if (rst) begin
            exp_ir  = '0;
            exp_cnt = '0;
            sb.delete();
        end else begin
            if (took) begin
                exp_ir    = d;
                in_decode = 1'b1;
            end
            if (prev_exec) exp_cnt = exp_cnt + 4'd1;
        end
        prev_exec = 1'b0;
        mem_ack = 1'b0;
        if (mem_req && mem_en) begin
            if (wait_n >= ack_delay && prog.size() > 0) begin
                e = prog.pop_front();
                mem_ack  = 1'b1;
                mem_data = e.data;
                sb.push_back(e);
                wait_n = 0;
            end else begin
                wait_n++;
            end
        end else if (!mem_req) begin
            wait_n = 0;
        end
        #1;
        check("ir_value", ir, exp_ir);
        check("instr_count", instr_count, exp_cnt);
        check("strobe_outside_exec", (reg_wr_strobe | stat_wr_strobe) & ~(pc_load | pc_inc), 0);
        check("pc_exclusive", pc_load & pc_inc, 0);
        if (pc_load | pc_inc) begin
            prev_exec = 1'b1;
            n_exec++;
            exec_gap = cyc - last_exec_cyc;
            last_exec_cyc = cyc;
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("exec_ir", ir, e.data);
                check("reg_wr_strobe", reg_wr_strobe, e.e_reg);
                check("stat_wr_strobe", stat_wr_strobe, e.e_stat);
                check("pc_load", pc_load, e.e_load);
                check("pc_inc", pc_inc, !e.e_load);
            end
            $display("[TB] exec #%0d ir=%04h reg=%0b stat=%0b load=%0b inc=%0b cnt=%0d",
                     n_exec, ir, reg_wr_strobe, stat_wr_strobe, pc_load, pc_inc, instr_count);
        end
    endtask

    task automatic wait_exec(input int target);
        int k = 0;
        while (n_exec < target && k < 300) begin
            cycle();
            k++;
        end
        check("exec_reached", n_exec, target);
    endtask

    task automatic wait_decode();
        int k = 0;
        cycle();
        while (!in_decode && k < 50) begin
            cycle();
            k++;
        end
        check("decode_reached", in_decode, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int req;
        int k;
        int base;
        reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        mem_ack = 1'b0; mem_data = '0;

        // Reset state
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        check("rst_halted", halted, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_ir", ir, 16'h0000);
        check("rst_count", instr_count, 0);

        // Continuous run, ack in the first FETCH cycle
        add(16'h0800, 1, 1, 0);
        add(16'h4800, 1, 0, 0);
        add(16'h0000, 0, 0, 0);
        c0 = cyc;
        run = 1'b1;
        wait_exec(1);
        check("t1_first_exec_latency", cyc - c0, 3);
        wait_exec(2);
        check("t1_gap2", exec_gap, 3);
        cycle();
        run = 1'b0;
        wait_exec(3);
        check("t1_gap3", exec_gap, 3);
        check("t1_exec3_cycle", cyc - c0, 9);
        cycle();
        check("t1_count", instr_count, 3);
        check("t1_idle", halted, 1);

        // Single step with a jump
        add(16'h8005, 0, 0, 1);
        base = n_exec;
        step = 1'b1;
        cycle();
        step = 1'b0;
        check("step_fetch", mem_req, 1);
        wait_exec(base + 1);
        cycle();
        check("step_idle", halted, 1);
        check("step_count1", instr_count, 4);
        mem_ack = 1'b1;
        mem_data = 16'hBEEF;
        cycle();
        cycle();
        check("ack_in_idle_still_halted", halted, 1);
        add(16'h8005, 0, 0, 1);
        step = 1'b1;
        cycle();
        step = 1'b0;
        wait_exec(base + 2);
        cycle();
        check("step_count2", instr_count, 5);

        // Ack delayed by four cycles
        ack_delay = 4;
        add(16'h4800, 1, 0, 0);
        base = n_exec;
        run = 1'b1;
        cycle();
        run = 1'b0;
        req = 0;
        k = 0;
        while (n_exec < base + 1 && k < 50) begin
            if (mem_req) req++;
            cycle();
            k++;
        end
        check("delay_req_cycles", req, 5);
        check("delay_no_error", bus_error, 0);
        ack_delay = 0;
        cycle();

        // Fetch timeout
        mem_en = 1'b0;
        run = 1'b1;
        req = 0;
        k = 0;
        while (!bus_error && k < 40) begin
            cycle();
            if (mem_req) req++;
            k++;
        end
        check("timeout_cycles", req, 15);
        check("err_bus_error", bus_error, 1);
        check("err_halted", halted, 1);
        check("err_mem_req", mem_req, 0);
        for (int i = 0; i < 5; i++) begin
            step = i[0];
            mem_ack = 1'b1;
            mem_data = 16'h1111;
            cycle();
        end
        step = 1'b0;
        check("err_sticky", bus_error, 1);
        check("err_no_req", mem_req, 0);
        run = 1'b0;
        mem_en = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("err_cleared", bus_error, 0);
        check("err_reset_halted", halted, 1);
        check("err_reset_count", instr_count, 0);

        // halt_req behaviour
        add(16'h0800, 1, 1, 0);
        add(16'h4800, 1, 0, 0);
        run = 1'b1;
        wait_decode();
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        cycle();
        check("halt_pulse_keeps_running", mem_req, 1);
        wait_decode();
        halt_req = 1'b1;
        cycle();
        cycle();
        check("halt_held_idle", halted, 1);
        check("halt_held_no_req", mem_req, 0);
        cycle();
        cycle();
        check("halt_priority_idle", halted, 1);
        halt_req = 1'b0;
        run = 1'b0;
        cycle();
        check("halt_count", instr_count, 2);

        // Counter wrap: 2 + 14 = 16 -> 0
        for (int i = 0; i < 14; i++) add(16'h0000, 0, 0, 0);
        base = n_exec;
        run = 1'b1;
        wait_exec(base + 13);
        cycle();
        run = 1'b0;
        wait_exec(base + 14);
        cycle();
        check("wrap_to_zero", instr_count, 0);

        // Bring counter to 15, then reset mid-fetch with ack pending
        for (int i = 0; i < 15; i++) add(16'h0000, 0, 0, 0);
        base = n_exec;
        run = 1'b1;
        wait_exec(base + 14);
        cycle();
        run = 1'b0;
        wait_exec(base + 15);
        cycle();
        check("count_at_15", instr_count, 15);
        mem_en = 1'b0;
        run = 1'b1;
        cycle();
        check("rf_in_fetch", mem_req, 1);
        mem_ack = 1'b1;
        mem_data = 16'h1234;
        reset = 1'b1;
        #1;
        check("rf_no_strobe_rst_cycle", {reg_wr_strobe, stat_wr_strobe, pc_load, pc_inc}, 0);
        cycle();
        check("rf_halted", halted, 1);
        check("rf_mem_req", mem_req, 0);
        check("rf_ir", ir, 16'h0000);
        check("rf_count", instr_count, 0);
        check("rf_bus_error", bus_error, 0);
        check("rf_no_strobe", {reg_wr_strobe, stat_wr_strobe, pc_load, pc_inc}, 0);
        reset = 1'b0;
        run = 1'b0;
        mem_en = 1'b1;
        cycle();
        check("rf_no_strobe_after", {reg_wr_strobe, stat_wr_strobe, pc_load, pc_inc}, 0);
        check("rf_after_halted", halted, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
